fetch_unit: RTL and testbench

- Instruction fetch stage of the 16-bit RISC core; sits directly upstream of the opcode decoder/control unit.
- Holds the PC and issues single-outstanding requests to instruction memory.
- Presents each fetched instruction, with its PC, to the decoder over a valid/ready handshake.
- Consumes the decoder's beq/bne/j flags plus the ALU zero flag to redirect the PC on taken branches and jumps.

---
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 62 ++++++
 tb/tb_fetch_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundle of instruction-memory, decoder handshake and branch-resolution signals
// master: fetch unit side (drives imem_req/imem_addr and the instr_* buffer outputs)
// slave:  environment side (memory, decoder and ALU drive responses and branch flags)
interface fetch_unit_if #(parameter int WIDTH = 16);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;
  logic             instr_valid;
  logic             instr_ready;
  logic [WIDTH-1:0] instr_out;
  logic [WIDTH-1:0] instr_pc;
  logic             br_resolve;
  logic             br_beq;
  logic             br_bne;
  logic             br_j;
  logic             alu_zero;
  logic [WIDTH-1:0] br_pc;
  logic [5:0]       br_imm;
  logic [11:0]      jmp_target;
  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    input  imem_rvalid, imem_rdata, instr_ready,
           br_resolve, br_beq, br_bne, br_j, alu_zero, br_pc, br_imm, jmp_target
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    output imem_rvalid, imem_rdata, instr_ready,
           br_resolve, br_beq, br_bne, br_j, alu_zero, br_pc, br_imm, jmp_target
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC holder issuing single-outstanding imem requests, buffering one instruction for the decoder
// clk/rst: rising-edge clock, synchronous active-high reset
// bus (master): imem_req/imem_addr out, imem_rvalid/imem_rdata in; instr_valid/instr_out/instr_pc out,
//               instr_ready in; br_resolve/br_beq/br_bne/br_j/alu_zero/br_pc/br_imm/jmp_target in
module fetch_unit #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DRAIN} state_e;
  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] instr_out_q;
  logic [WIDTH-1:0] instr_pc_q;
  logic             instr_valid_q;
  logic             taken;
  logic [WIDTH-1:0] target;
  always_comb begin
    taken  = bus.br_resolve && (bus.br_j || (bus.br_beq && bus.alu_zero) || (bus.br_bne && !bus.alu_zero));
    target = bus.br_j ? {bus.br_pc[WIDTH-1:12], bus.jmp_target}
                      : bus.br_pc + WIDTH'(1) + {{(WIDTH-6){bus.br_imm[5]}}, bus.br_imm};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      instr_valid_q <= 1'b0;
      instr_out_q   <= '0;
      instr_pc_q    <= '0;
    end else if (taken) begin
      // a request still in flight must be drained so its stale response is not buffered
      pc_q          <= target;
      instr_valid_q <= 1'b0;
      state_q       <= ((state_q == WAIT && !bus.imem_rvalid) || state_q == DRAIN) ? DRAIN : FETCH;
    end else begin
      case (state_q)
        FETCH: state_q <= WAIT;
        WAIT: if (bus.imem_rvalid) begin
          instr_out_q   <= bus.imem_rdata;
          instr_pc_q    <= pc_q;
          instr_valid_q <= 1'b1;
          pc_q          <= pc_q + WIDTH'(1);
          state_q       <= HOLD;
        end
        HOLD: if (bus.instr_ready) begin
          instr_valid_q <= 1'b0;
          state_q       <= FETCH;
        end
        DRAIN: if (bus.imem_rvalid) state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end
  end
  assign bus.imem_req    = !rst && state_q != HOLD;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr_out   = instr_out_q;
  assign bus.instr_pc    = instr_pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a latency-configurable memory and a transaction-level model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fetch_unit_if #(.WIDTH(16)) bus();
  fetch_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] memval(logic [15:0] a);
    case (a)
      16'h0000: return 16'h0123;
      16'h0001: return 16'h1456;
      16'h0002: return 16'h2789;
      default:  return a ^ 16'hC3A5;
    endcase
  endfunction
  int          lat = 1;
  logic        busy = 1'b0;
  int          cnt = 0;
  logic [15:0] maddr = '0;
  always @(negedge clk) begin
    bus.imem_rvalid = 1'b0;
    if (rst) busy = 1'b0;
    else if (busy) begin
      cnt--;
      if (cnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = memval(maddr);
        busy = 1'b0;
      end
    end else if (bus.imem_req) begin
      busy  = 1'b1;
      cnt   = lat;
      maddr = bus.imem_addr;
    end
  end
  logic        m_valid = 1'b0;
  logic        m_outst = 1'b0;
  logic        m_drop  = 1'b0;
  logic [15:0] m_pc = '0;
  logic [15:0] m_out = '0;
  logic [15:0] m_ipc = '0;
  bit          armed = 1'b0;
  always @(posedge clk) begin
    logic        tk, req;
    logic [15:0] tgt;
    if (rst) begin
      m_pc = 16'h0000; m_valid = 0; m_out = 0; m_ipc = 0; m_outst = 0; m_drop = 0; armed = 1;
    end else begin
      req = !m_valid;
      tk  = bus.br_resolve && (bus.br_j || (bus.br_beq && bus.alu_zero) || (bus.br_bne && !bus.alu_zero));
      tgt = bus.br_j ? ((bus.br_pc & 16'hF000) | {4'h0, bus.jmp_target})
                     : 16'(int'(bus.br_pc) + 1 + int'($signed(bus.br_imm)));
      if (tk) begin
        m_drop  = m_outst && !bus.imem_rvalid;
        m_outst = m_drop;
        m_pc    = tgt;
        m_valid = 0;
      end else begin
        if (bus.imem_rvalid && m_outst && !m_drop) begin
          m_valid = 1; m_out = bus.imem_rdata; m_ipc = m_pc; m_pc = m_pc + 16'd1;
        end else if (m_valid && bus.instr_ready) m_valid = 0;
        if (bus.imem_rvalid) m_drop = 0;
        m_outst = req && !bus.imem_rvalid;
      end
    end
  end
  always @(negedge clk) if (armed) begin
    tests++;
    if (bus.imem_req !== (!rst && !m_valid) || bus.imem_addr !== m_pc || bus.instr_valid !== m_valid ||
        (m_valid && (bus.instr_out !== m_out || bus.instr_pc !== m_ipc))) begin
      fails++;
      $display("FAIL model t=%0t req=%b/%b addr=%h/%h valid=%b/%b out=%h/%h pc=%h/%h", $time,
               bus.imem_req, !rst && !m_valid, bus.imem_addr, m_pc, bus.instr_valid, m_valid,
               bus.instr_out, m_out, bus.instr_pc, m_ipc);
    end
  end
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(string name);
    int n = 0;
    while (!bus.instr_valid && n < 50) begin tick(); n++; end
    if (!bus.instr_valid) begin
      tests++; fails++;
      $display("FAIL %s: instr_valid timeout got 0 expected 1", name);
    end
  endtask
  task automatic clear_br();
    bus.br_resolve = 0; bus.br_beq = 0; bus.br_bne = 0; bus.br_j = 0; bus.alu_zero = 0;
    bus.br_pc = '0; bus.br_imm = '0; bus.jmp_target = '0;
  endtask
  initial begin
    logic [15:0] held;
    bit          seen;
    clear_br();
    bus.instr_ready = 1;
    tick(2);
    check("rst_valid", 16'(bus.instr_valid), 16'd0);
    check("rst_req", 16'(bus.imem_req), 16'd0);
    check("rst_addr", bus.imem_addr, 16'h0000);
    check("rst_out", bus.instr_out, 16'h0000);
    check("rst_ipc", bus.instr_pc, 16'h0000);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      wait_valid("seq");
      check("seq_pc", bus.instr_pc, 16'(i));
      check("seq_out", bus.instr_out, (i == 0) ? 16'h0123 : (i == 1) ? 16'h1456 : 16'h2789);
      tick();
      check("seq_once", 16'(bus.instr_valid), 16'd0);
      check("seq_addr", bus.imem_addr, 16'(i + 1));
    end
    bus.instr_ready = 0;
    wait_valid("bp");
    held = bus.instr_out;
    check("bp_data", held, 16'hC3A6);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 16'(bus.instr_valid), 16'd1);
      check("bp_out", bus.instr_out, held);
      check("bp_req", 16'(bus.imem_req), 16'd0);
    end
    bus.instr_ready = 1;
    tick();
    check("bp_rel_req", 16'(bus.imem_req), 16'd1);
    check("bp_rel_addr", bus.imem_addr, 16'h0004);
    bus.instr_ready = 0;
    wait_valid("beq_setup");
    bus.br_resolve = 1; bus.br_beq = 1; bus.alu_zero = 1; bus.br_pc = 16'h0010; bus.br_imm = 6'b111110;
    bus.instr_ready = 1;
    tick();
    clear_br();
    bus.instr_ready = 0;
    check("beq_flush", 16'(bus.instr_valid), 16'd0);
    check("beq_addr", bus.imem_addr, 16'h000F);
    wait_valid("beq_fetch");
    check("beq_ipc", bus.instr_pc, 16'h000F);
    bus.br_resolve = 1; bus.br_beq = 1; bus.alu_zero = 0; bus.br_pc = 16'h0010; bus.br_imm = 6'b111110;
    tick();
    clear_br();
    check("nt_valid", 16'(bus.instr_valid), 16'd1);
    check("nt_addr", bus.imem_addr, 16'h0010);
    bus.instr_ready = 1;
    tick();
    lat = 4;
    tick();
    bus.br_resolve = 1; bus.br_j = 1; bus.br_beq = 1; bus.alu_zero = 1;
    bus.br_pc = 16'h3000; bus.jmp_target = 12'hABC; bus.br_imm = 6'b111110;
    tick();
    clear_br();
    check("j_req", 16'(bus.imem_req), 16'd1);
    check("j_addr", bus.imem_addr, 16'h3ABC);
    wait_valid("j_fetch");
    check("j_ipc", bus.instr_pc, 16'h3ABC);
    check("j_out", bus.instr_out, 16'hF919);
    tick();
    lat = 2;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk); #1;
      seen = bus.imem_rvalid;
    end
    check("co_rvalid", 16'(seen), 16'd1);
    bus.br_resolve = 1; bus.br_bne = 1; bus.alu_zero = 0; bus.br_pc = 16'hFFFF; bus.br_imm = 6'd0;
    @(posedge clk); #1;
    clear_br();
    check("co_valid", 16'(bus.instr_valid), 16'd0);
    check("co_req", 16'(bus.imem_req), 16'd1);
    check("co_addr", bus.imem_addr, 16'h0000);
    wait_valid("co_fetch");
    check("co_ipc", bus.instr_pc, 16'h0000);
    check("co_out", bus.instr_out, 16'h0123);
    tick();
    lat = 3;
    tick();
    rst = 1;
    tick();
    check("rw_valid", 16'(bus.instr_valid), 16'd0);
    check("rw_req", 16'(bus.imem_req), 16'd0);
    check("rw_addr", bus.imem_addr, 16'h0000);
    rst = 0;
    wait_valid("rw_fetch");
    check("rw_ipc", bus.instr_pc, 16'h0000);
    check("rw_out", bus.instr_out, 16'h0123);
    tick();
    bus.instr_ready = 0;
    wait_valid("rh_setup");
    check("rh_pre", bus.instr_pc, 16'h0001);
    rst = 1;
    tick();
    check("rh_valid", 16'(bus.instr_valid), 16'd0);
    check("rh_req", 16'(bus.imem_req), 16'd0);
    check("rh_addr", bus.imem_addr, 16'h0000);
    rst = 0;
    bus.instr_ready = 1;
    wait_valid("rh_fetch");
    check("rh_ipc", bus.instr_pc, 16'h0000);
    tick(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
